// File: rtl/event_recorder_if.sv
// Event recorder bus: trigger/TOT/singles inputs, run control, FIFO readout and run counters.
interface event_recorder_if #(
    parameter int unsigned DEPTH_LOG2 = 8
);
    logic                  trigger_active;
    logic                  live_acquisition;
    logic                  signal_line_1;
    logic                  signal_line_2;
    logic [15:0]           tot_short;
    logic [15:0]           tot_long;
    logic                  clear;
    logic                  rd_req;
    logic [63:0]           rd_data;
    logic                  rd_valid;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic [31:0]           ntriggers;
    logic [15:0]           ndropped;
    logic [31:0]           live_time;
    logic [31:0]           nsingles1;
    logic [31:0]           nsingles2;

    modport slave (
        input  trigger_active, live_acquisition, signal_line_1, signal_line_2,
        input  tot_short, tot_long, clear, rd_req,
        output rd_data, rd_valid, fifo_count, ntriggers, ndropped, live_time,
        output nsingles1, nsingles2
    );

    modport master (
        output trigger_active, live_acquisition, signal_line_1, signal_line_2,
        output tot_short, tot_long, clear, rd_req,
        input  rd_data, rd_valid, fifo_count, ntriggers, ndropped, live_time,
        input  nsingles1, nsingles2
    );
endinterface

// File: rtl/event_recorder.sv
// Trigger event recorder: timestamps rising trigger edges into a FWFT event FIFO, keeps run counters.
// Singles counters are built only when EVENT_RECORDER_SINGLES_EN is defined.
module event_recorder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned TS_W       = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    event_recorder_if.slave bus
);
    localparam int unsigned Depth = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CountFull = (DEPTH_LOG2 + 1)'(Depth);

    logic                trig_q;
    logic                arm_q;
    logic                strobe;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic                wr_valid_q, wr_valid_d;
    logic [63:0]         wr_data_q, wr_data_d;
    logic [63:0]         mem [Depth];
    logic [DEPTH_LOG2:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0] count_q, count_d;
    logic                rd_valid_q, rd_valid_d;
    logic [63:0]         rd_data_q, rd_data_d;
    logic [31:0]         ntrig_q, ntrig_d;
    logic [15:0]         ndrop_q, ndrop_d;
    logic [31:0]         live_q, live_d;
    logic                pop;
    logic                load;
    logic                ram_empty;

    // arm_q masks the first cycle after reset so a trigger held high across release is no edge
    assign strobe    = bus.trigger_active & ~trig_q & arm_q;
    assign pop       = rd_valid_q & bus.rd_req;
    assign ram_empty = (wptr_q == rptr_q);
    assign load      = ~bus.clear & (~rd_valid_q | pop) & ~ram_empty;

    always_comb begin
        ts_d       = ts_q + 1'b1;
        wr_valid_d = 1'b0;
        wr_data_d  = wr_data_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        ntrig_d    = ntrig_q;
        ndrop_d    = ndrop_q;
        live_d     = live_q;
        if (bus.clear) begin
            ts_d       = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            rd_valid_d = 1'b0;
            ntrig_d    = '0;
            ndrop_d    = '0;
            live_d     = '0;
        end else begin
            if (strobe) begin
                ntrig_d = ntrig_q + 32'd1;
                // Fullness uses the count before any same-cycle pop
                if (count_q == CountFull) begin
                    if (ndrop_q != 16'hFFFF) ndrop_d = ndrop_q + 16'd1;
                end else begin
                    wr_valid_d = 1'b1;
                    wr_data_d  = {32'(ts_q), bus.tot_long, bus.tot_short};
                end
            end
            if (wr_valid_q) wptr_d = wptr_q + 1'b1;
            if (load) begin
                rptr_d     = rptr_q + 1'b1;
                rd_data_d  = mem[rptr_q[DEPTH_LOG2-1:0]];
                rd_valid_d = 1'b1;
            end else if (pop) begin
                rd_valid_d = 1'b0;
            end
            count_d = count_q + (DEPTH_LOG2 + 1)'(wr_valid_q) - (DEPTH_LOG2 + 1)'(pop);
            if (bus.live_acquisition && live_q != 32'hFFFF_FFFF) live_d = live_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q     <= 1'b0;
            arm_q      <= 1'b0;
            ts_q       <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ntrig_q    <= '0;
            ndrop_q    <= '0;
            live_q     <= '0;
        end else begin
            trig_q     <= bus.trigger_active;
            arm_q      <= 1'b1;
            ts_q       <= ts_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ntrig_q    <= ntrig_d;
            ndrop_q    <= ndrop_d;
            live_q     <= live_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid_q && !bus.clear) mem[wptr_q[DEPTH_LOG2-1:0]] <= wr_data_q;
    end

`ifdef EVENT_RECORDER_SINGLES_EN
    logic        s1_q, s2_q;
    logic [31:0] ns1_q, ns2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            ns1_q <= '0;
            ns2_q <= '0;
        end else begin
            s1_q <= bus.signal_line_1;
            s2_q <= bus.signal_line_2;
            if (bus.clear) begin
                ns1_q <= '0;
                ns2_q <= '0;
            end else begin
                if (bus.signal_line_1 && !s1_q && arm_q) ns1_q <= ns1_q + 32'd1;
                if (bus.signal_line_2 && !s2_q && arm_q) ns2_q <= ns2_q + 32'd1;
            end
        end
    end

    assign bus.nsingles1 = ns1_q;
    assign bus.nsingles2 = ns2_q;
`else
    logic unused_singles;
    assign unused_singles = bus.signal_line_1 ^ bus.signal_line_2;
    assign bus.nsingles1  = '0;
    assign bus.nsingles2  = '0;
`endif

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.fifo_count = count_q;
    assign bus.ntriggers  = ntrig_q;
    assign bus.ndropped   = ndrop_q;
    assign bus.live_time  = live_q;
endmodule

// File: tb/tb_event_recorder.sv
// Bench for event_recorder: event-queue model checked every cycle plus hand-computed directed checks.
module tb_event_recorder;
    localparam int unsigned DL    = 8;
    localparam int unsigned Depth = 2 ** DL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    event_recorder_if #(.DEPTH_LOG2(DL)) bus ();

    event_recorder #(.DEPTH_LOG2(DL), .TS_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: events wait in a queue tagged with the cycle they are first counted in
    typedef struct {
        logic [63:0] word;
        longint      vis;
    } ev_t;

    ev_t         stored[$];
    logic        m_head_valid;
    logic [63:0] m_head;
    longint      cyc = 0;
    logic [31:0] m_ts, m_ntrig, m_live, m_s1, m_s2;
    logic [15:0] m_drop;
    logic        m_prev, m_p1, m_p2;

    function automatic int vis_count(input longint c);
        int n = 0;
        foreach (stored[i]) if (stored[i].vis <= c) n++;
        return n;
    endfunction

    function automatic int exp_count(input longint c);
        return (m_head_valid ? 1 : 0) + vis_count(c);
    endfunction

    task automatic model_reset();
        stored.delete();
        m_head_valid = 1'b0;
        m_head       = '0;
        m_ts = '0; m_ntrig = '0; m_live = '0; m_s1 = '0; m_s2 = '0; m_drop = '0;
        // Lines count as already high at reset so a level held across release is no edge
        m_prev = 1'b1; m_p1 = 1'b1; m_p2 = 1'b1;
    endtask

    task automatic model_step();
        int   cur;
        logic strobe;
        cur    = exp_count(cyc);
        strobe = bus.trigger_active && !m_prev;
        if (bus.clear) begin
            stored.delete();
            m_head_valid = 1'b0;
            m_ts = '0; m_ntrig = '0; m_live = '0; m_s1 = '0; m_s2 = '0; m_drop = '0;
        end else begin
            if (m_head_valid && bus.rd_req) m_head_valid = 1'b0;
            if (!m_head_valid && stored.size() > 0 && stored[0].vis <= cyc) begin
                m_head       = stored[0].word;
                m_head_valid = 1'b1;
                void'(stored.pop_front());
            end
            if (strobe) begin
                m_ntrig++;
                if (cur == Depth) begin
                    if (m_drop != 16'hFFFF) m_drop++;
                end else begin
                    stored.push_back('{word: {m_ts, bus.tot_long, bus.tot_short}, vis: cyc + 2});
                end
            end
            if (bus.live_acquisition && m_live != 32'hFFFF_FFFF) m_live++;
`ifdef EVENT_RECORDER_SINGLES_EN
            if (bus.signal_line_1 && !m_p1) m_s1++;
            if (bus.signal_line_2 && !m_p2) m_s2++;
`endif
            m_ts++;
        end
        m_prev = bus.trigger_active;
        m_p1   = bus.signal_line_1;
        m_p2   = bus.signal_line_2;
        cyc++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_fifo_count", 64'(bus.fifo_count), 64'(exp_count(cyc)));
            check("cyc_rd_valid", 64'(bus.rd_valid), 64'(m_head_valid));
            if (m_head_valid) check("cyc_rd_data", bus.rd_data, m_head);
            check("cyc_ntriggers", 64'(bus.ntriggers), 64'(m_ntrig));
            check("cyc_ndropped", 64'(bus.ndropped), 64'(m_drop));
            check("cyc_live_time", 64'(bus.live_time), 64'(m_live));
            check("cyc_nsingles1", 64'(bus.nsingles1), 64'(m_s1));
            check("cyc_nsingles2", 64'(bus.nsingles2), 64'(m_s2));
        end
    end

    task automatic pulse(input logic [15:0] ts_short, input logic [15:0] ts_long);
        bus.tot_short      = ts_short;
        bus.tot_long       = ts_long;
        bus.trigger_active = 1'b1;
        @(negedge clk);
        bus.trigger_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        logic [31:0] last_ts;
        int          pops;
        bus.trigger_active   = 1'b0;
        bus.live_acquisition = 1'b0;
        bus.signal_line_1    = 1'b0;
        bus.signal_line_2    = 1'b0;
        bus.tot_short        = '0;
        bus.tot_long         = '0;
        bus.clear            = 1'b0;
        bus.rd_req           = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset_ntriggers", 64'(bus.ntriggers), 64'd0);
        rst_n = 1'b1;

        // First event: edge lands in the cycle whose timestamp is 0x40
        repeat (64) @(negedge clk);
        bus.tot_short      = 16'h0012;
        bus.tot_long       = 16'h0345;
        bus.trigger_active = 1'b1;
        @(negedge clk);
        check("first_ntriggers", 64'(bus.ntriggers), 64'd1);
        check("first_rd_valid_n1", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        check("first_count_n2", 64'(bus.fifo_count), 64'd1);
        check("first_rd_valid_n2", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        check("first_rd_valid_n3", 64'(bus.rd_valid), 64'd1);
        check("first_rd_data", bus.rd_data, 64'h00000040_0345_0012);
        repeat (2) @(negedge clk);
        bus.trigger_active = 1'b0;
        bus.rd_req         = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("first_pop_count", 64'(bus.fifo_count), 64'd0);
        check("first_pop_valid", 64'(bus.rd_valid), 64'd0);

        // Overflow: 300 triggers into a 256-deep FIFO
        do_clear();
        for (int i = 0; i < 300; i++) pulse(16'(i), 16'(~i));
        repeat (4) @(negedge clk);
        check("ovf_fifo_count", 64'(bus.fifo_count), 64'd256);
        check("ovf_ndropped", 64'(bus.ndropped), 64'd44);
        check("ovf_ntriggers", 64'(bus.ntriggers), 64'd300);

        // Full FIFO: strobe and pop together, the event is still dropped
        bus.trigger_active = 1'b1;
        bus.rd_req         = 1'b1;
        @(negedge clk);
        bus.trigger_active = 1'b0;
        bus.rd_req         = 1'b0;
        repeat (2) @(negedge clk);
        check("fullpop_ndropped", 64'(bus.ndropped), 64'd45);
        check("fullpop_count", 64'(bus.fifo_count), 64'd255);

        last_ts    = '0;
        pops       = 0;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!bus.rd_valid) break;
            check("drain_ts_increasing", 64'(bus.rd_data[63:32] > last_ts), 64'd1);
            last_ts = bus.rd_data[63:32];
            pops++;
            @(negedge clk);
        end
        bus.rd_req = 1'b0;
        check("drain_pops", 64'(pops), 64'd255);
        @(negedge clk);
        check("drain_empty", 64'(bus.fifo_count), 64'd0);

        // CLEAR together with a strobe while 3 events are stored
        do_clear();
        repeat (3) pulse(16'h1, 16'h2);
        repeat (4) @(negedge clk);
        check("pre_clear_count", 64'(bus.fifo_count), 64'd3);
        bus.clear          = 1'b1;
        bus.trigger_active = 1'b1;
        @(negedge clk);
        bus.clear          = 1'b0;
        bus.trigger_active = 1'b0;
        check("clear_count", 64'(bus.fifo_count), 64'd0);
        check("clear_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("clear_ntriggers", 64'(bus.ntriggers), 64'd0);
        @(negedge clk);
        bus.tot_short      = 16'hAAAA;
        bus.tot_long       = 16'h5555;
        bus.trigger_active = 1'b1;
        repeat (3) @(negedge clk);
        bus.trigger_active = 1'b0;
        check("clear_ts_restart", bus.rd_data, 64'h00000001_5555_AAAA);
        bus.rd_req = 1'b1;
        @(negedge clk);
        bus.rd_req = 1'b0;

        // Live time and singles
        do_clear();
        bus.live_acquisition = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bus.signal_line_1 = (i % 20 == 5) && (i < 140);
            bus.signal_line_2 = (i % 50 == 10) && (i < 150);
            @(negedge clk);
        end
        check("live_time", 64'(bus.live_time), 64'd1000);
        bus.live_acquisition = 1'b0;
        bus.signal_line_1    = 1'b0;
        bus.signal_line_2    = 1'b0;
`ifdef EVENT_RECORDER_SINGLES_EN
        check("nsingles1", 64'(bus.nsingles1), 64'd7);
        check("nsingles2", 64'(bus.nsingles2), 64'd3);
`else
        check("nsingles1_off", 64'(bus.nsingles1), 64'd0);
        check("nsingles2_off", 64'(bus.nsingles2), 64'd0);
`endif

        // Asynchronous reset in the middle of readout
        for (int i = 0; i < 10; i++) pulse(16'(i), 16'h77);
        repeat (4) @(negedge clk);
        bus.rd_req = 1'b1;
        repeat (3) @(negedge clk);
        bus.rd_req = 1'b0;
        check("pre_reset_count", 64'(bus.fifo_count), 64'd7);
        #2;
        rst_n              = 1'b0;
        bus.trigger_active = 1'b1;
        #1;
        check("areset_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("areset_rd_data", bus.rd_data, 64'd0);
        check("areset_fifo_count", 64'(bus.fifo_count), 64'd0);
        check("areset_ntriggers", 64'(bus.ntriggers), 64'd0);
        check("areset_live_time", 64'(bus.live_time), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("held_trig_ntriggers", 64'(bus.ntriggers), 64'd0);
        check("held_trig_count", 64'(bus.fifo_count), 64'd0);
        bus.trigger_active = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/event_recorder.md
# event_recorder

Downstream consumer of the trigger handler output on the CLK_FAST domain. On each rising edge of the final trigger it stamps a timestamp and the short/long TOT values into an on-chip event FIFO, and keeps run counters. The FIFO head and counters are exposed for readout through the I2C register map.

## Interface
Parameters:
- DEPTH_LOG2, 8: FIFO depth is 2^DEPTH_LOG2 events.
- TS_W, 32: timestamp counter width, 16..32.

Ports:
- CLK  in  1  fast acquisition clock (CLK_FAST)
- RESET  in  1  asynchronous, active-low reset
- TRIGGER_ACTIVE  in  1  trigger handler output; a rising edge is one event
- LIVE_ACQUISITION  in  1  high while acquisition is live
- SIGNAL_LINE_1, SIGNAL_LINE_2  in  1 each  discriminator lines, used for singles counting
- TOT_SHORT, TOT_LONG  in  16 each  TOT calculator outputs
- CLEAR  in  1  synchronous run clear (SOFT_RESET control bit)
- RD_REQ  in  1  pop request
- RD_DATA  out  64  event word: {TIMESTAMP zero-extended to 32, TOT_LONG, TOT_SHORT}
- RD_VALID  out  1  RD_DATA holds the FIFO head
- FIFO_COUNT  out  DEPTH_LOG2+1  events stored, including the head
- NTRIGGERS  out  32  accepted trigger edges
- NDROPPED  out  16  events lost to a full FIFO
- LIVE_TIME  out  32  CLK cycles with LIVE_ACQUISITION high
- NSINGLES1, NSINGLES2  out  32 each  rising-edge counts (macro-dependent)

## Operation
- Edge detect: register trig_d <= TRIGGER_ACTIVE. STROBE = TRIGGER_ACTIVE & !trig_d. Singles edges are detected the same way.
- Timestamp: free-running TS_W counter. +1 per cycle, wraps to 0, zeroed by CLEAR.
- On STROBE, capture {timestamp, TOT_LONG, TOT_SHORT} as sampled in that same cycle into a write register. The write into the RAM happens the next cycle.
- NTRIGGERS increments on every STROBE, including dropped events, and wraps.
- Fullness is judged on FIFO_COUNT at the capture cycle, before any same-cycle pop.
  - FIFO_COUNT == 2^DEPTH_LOG2: the event is discarded and NDROPPED increments, saturating at 0xFFFF.
  - A simultaneous pop does not rescue the event.
- Readout is first-word-fall-through behind an output register.
  - When RD_VALID=1 and RD_REQ=1, the head is consumed.
  - The next head is loaded, with RD_VALID held high, if another event exists; otherwise RD_VALID drops.
  - RD_REQ while RD_VALID=0 is ignored.
- Pointers wrap modulo 2^DEPTH_LOG2.
- LIVE_TIME increments each cycle LIVE_ACQUISITION=1 and saturates at 0xFFFFFFFF.
- CLEAR has priority over everything else:
  - empties the FIFO and zeroes the timestamp and all counters;
  - a STROBE in the same cycle is neither stored nor counted;
  - RD_VALID=0 on the next cycle.
- RESET low: all outputs 0, FIFO empty, trig_d=0. A trigger held high across the release of reset does not produce an event.

## Timing
- STROBE at cycle N:
  - write register loads at N+1, RAM written at N+1;
  - FIFO_COUNT increments at N+2;
  - from empty, RD_VALID=1 at N+3 with RD_DATA holding the event.
- Pop at cycle M: the next head is present, with RD_VALID=1, at M+1.
- Back-to-back pops every cycle are sustained.
- A STROBE is possible every second cycle (trigger low for at least one cycle). Capture throughput is one event per two cycles.
- Counter updates are visible one cycle after the causing input edge.

## Configuration
- EVENT_RECORDER_SINGLES_EN defined: NSINGLES1/NSINGLES2 count rising edges of SIGNAL_LINE_1/2, wrap at 2^32, and are zeroed by CLEAR.
- Not defined: the singles edge-detect and counter logic is removed. NSINGLES1/NSINGLES2 are tied to 0.

## Test plan
- Reset release, then one 5-cycle trigger pulse with TOT_SHORT=0x0012 and TOT_LONG=0x0345 at timestamp 0x40 -> RD_VALID=1 three cycles after the edge, RD_DATA=0x00000040_0345_0012, NTRIGGERS=1.
- 300 triggers with DEPTH_LOG2=8 and no reads -> FIFO_COUNT=256, NDROPPED=44, NTRIGGERS=300. Draining 256 pops returns timestamps in strictly increasing order.
- FIFO full, then STROBE and pop in the same cycle -> event dropped, NDROPPED+1, FIFO_COUNT=255 afterwards.
- CLEAR asserted in the same cycle as STROBE with 3 events stored -> next cycle FIFO_COUNT=0, RD_VALID=0, NTRIGGERS=0, timestamp restarts at 0.
- LIVE_ACQUISITION high for 1000 cycles; 7 pulses on SIGNAL_LINE_1, 3 on SIGNAL_LINE_2 -> LIVE_TIME=1000. With EVENT_RECORDER_SINGLES_EN: NSINGLES1=7, NSINGLES2=3. Without it: both 0.
- RESET asserted mid-readout with 10 events stored -> all outputs 0 immediately (asynchronous). After release, no event is recorded while TRIGGER_ACTIVE stays high.
